// File: rtl/nf_frame_sequencer_pkg.sv
// Shared types for the note-finder frame sequencer.
package nf_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        ON_COMMIT = 2'd1,
        REPEAT    = 2'd2
    } SeqMode;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        HOLDOFF = 2'd3
    } SeqState;

    // Encoding 3 is reserved and behaves like OFF.
    function automatic logic launchMode(input logic [1:0] m);
        return (m == ON_COMMIT) || (m == REPEAT);
    endfunction

endpackage

// File: rtl/nf_bin_bank.sv
// Double-buffered bin storage: write bank is ~rdSel, read bank is rdSel.
// Latency: write visible in its bank after one edge; read bank is a mux of registers.
// Backpressure: none; the caller gates wrEn, and indices >= BINS are ignored.
module nf_bin_bank #(
    parameter int N    = 16,
    parameter int BINS = 120,
    localparam int IW  = $clog2(BINS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrEn,
    input  logic [IW-1:0]              wrIdx,
    input  logic [N-1:0]               wrData,
    input  logic                       rdSel,
    output logic [BINS-1:0][N-1:0]     rdBank
);

    logic [BINS-1:0][N-1:0] bank0;
    logic [BINS-1:0][N-1:0] bank1;
    logic                   idxOk;

    assign idxOk = ({1'b0, wrIdx} < (IW + 1)'(BINS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank0 <= '0;
            bank1 <= '0;
        end else if (wrEn && idxOk) begin
            if (rdSel) begin
                bank0[wrIdx] <= wrData;
            end else begin
                bank1[wrIdx] <= wrData;
            end
        end
    end

    assign rdBank = rdSel ? bank1 : bank0;

endmodule

// File: rtl/nf_frame_sequencer.sv
// Frame driver: collects a bin frame, swaps banks and launches NoteFinder, waits for finished/timeout.
// Latency: commit at edge t -> swap, new dftBins and startCycle after edge t+1 (FSM idle).
// Backpressure: commitReady low while a frame is pending; extra commits are counted as overruns.
module nf_frame_sequencer
    import nf_frame_sequencer_pkg::*;
#(
    parameter int N            = 16,
    parameter int BPO          = 24,
    parameter int OCT          = 5,
    parameter int TIMEOUT      = 1023,
    parameter int MIN_INTERVAL = 0,
    localparam int BINS        = BPO * OCT,
    localparam int IW          = $clog2(BINS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   binWrEn,
    input  logic [IW-1:0]          binWrIdx,
    input  logic [N-1:0]           binWrData,
    input  logic                   frameCommit,
    output logic                   commitReady,
    output logic [BINS-1:0][N-1:0] dftBins,
    output logic                   startCycle,
    input  logic                   nfFinished,
    output logic                   busy,
    output logic [15:0]            frameCount,
    output logic [7:0]             overrunCount,
    output logic                   timeoutFlag
);

    localparam int CMAX = (TIMEOUT > MIN_INTERVAL) ? TIMEOUT : MIN_INTERVAL;
    localparam int CW   = ($clog2(CMAX + 1) < 1) ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);
    localparam logic [CW-1:0] HO_LAST = CW'((MIN_INTERVAL > 0) ? MIN_INTERVAL - 1 : 0);
    localparam SeqState AFTER_WAIT    = (MIN_INTERVAL > 0) ? HOLDOFF : IDLE;

    SeqState       state;
    SeqState       nextState;
    logic          rdSel;
    logic          pending;
    logic          everSwapped;
    logic [CW-1:0] cnt;

    logic swap;
    logic cntClr;
    logic cntInc;
    logic finishHit;
    logic timeoutHit;

    nf_bin_bank #(.N(N), .BINS(BINS)) uBank (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (binWrEn && !pending),
        .wrIdx  (binWrIdx),
        .wrData (binWrData),
        .rdSel  (rdSel),
        .rdBank (dftBins)
    );

    assign commitReady = ~pending;

    always_comb begin
        nextState  = state;
        swap       = 1'b0;
        cntClr     = 1'b0;
        cntInc     = 1'b0;
        finishHit  = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (launchMode(mode) && pending) begin
                    swap      = 1'b1;
                    nextState = START;
                end else if ((mode == REPEAT) && everSwapped) begin
                    nextState = START;
                end
            end
            START: begin
                cntClr    = 1'b1;
                nextState = WAIT;
            end
            WAIT: begin
                if (nfFinished) begin
                    finishHit = 1'b1;
                    cntClr    = 1'b1;
                    nextState = AFTER_WAIT;
                end else if (cnt == TO_LAST) begin
                    timeoutHit = 1'b1;
                    cntClr     = 1'b1;
                    nextState  = AFTER_WAIT;
                end else begin
                    cntInc = 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt == HO_LAST) begin
                    nextState = IDLE;
                end else begin
                    cntInc = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rdSel        <= 1'b0;
            pending      <= 1'b0;
            everSwapped  <= 1'b0;
            cnt          <= '0;
            startCycle   <= 1'b0;
            busy         <= 1'b0;
            frameCount   <= '0;
            overrunCount <= '0;
            timeoutFlag  <= 1'b0;
        end else begin
            state      <= nextState;
            startCycle <= (nextState == START);
            busy       <= (nextState != IDLE);

            if (cntClr) begin
                cnt <= '0;
            end else if (cntInc) begin
                cnt <= cnt + 1'b1;
            end

            // A swap only happens with pending set, so a same-cycle commit is an overrun.
            if (swap) begin
                rdSel       <= ~rdSel;
                pending     <= 1'b0;
                everSwapped <= 1'b1;
            end else if (frameCommit && !pending) begin
                pending <= 1'b1;
            end

            if (frameCommit && pending && (overrunCount != 8'hFF)) begin
                overrunCount <= overrunCount + 8'd1;
            end

            if (finishHit) begin
                frameCount <= frameCount + 16'd1;
            end
            if (timeoutHit) begin
                timeoutFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nf_frame_sequencer.sv
// Directed, self-checking bench for nf_frame_sequencer.
module tb_nf_frame_sequencer;

    localparam int N            = 16;
    localparam int BPO          = 24;
    localparam int OCT          = 5;
    localparam int BINS         = BPO * OCT;
    localparam int IW           = $clog2(BINS);
    localparam int TIMEOUT      = 1023;
    localparam int MIN_INTERVAL = 10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             mode;
    logic                   binWrEn;
    logic [IW-1:0]          binWrIdx;
    logic [N-1:0]           binWrData;
    logic                   frameCommit;
    logic                   commitReady;
    logic [BINS-1:0][N-1:0] dftBins;
    logic                   startCycle;
    logic                   nfFinished;
    logic                   busy;
    logic [15:0]            frameCount;
    logic [7:0]             overrunCount;
    logic                   timeoutFlag;

    int checks = 0;
    int errors = 0;

    nf_frame_sequencer #(
        .N(N), .BPO(BPO), .OCT(OCT), .TIMEOUT(TIMEOUT), .MIN_INTERVAL(MIN_INTERVAL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .binWrEn      (binWrEn),
        .binWrIdx     (binWrIdx),
        .binWrData    (binWrData),
        .frameCommit  (frameCommit),
        .commitReady  (commitReady),
        .dftBins      (dftBins),
        .startCycle   (startCycle),
        .nfFinished   (nfFinished),
        .busy         (busy),
        .frameCount   (frameCount),
        .overrunCount (overrunCount),
        .timeoutFlag  (timeoutFlag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        wrEn;
        logic [6:0]  idx;
        logic [15:0] data;
        logic        commit;
        logic        expReady;
        logic [7:0]  expOvr;
        logic        expBusy;
        logic        expStart;
        logic [15:0] expBin5;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, " startCycle"}, 32'(startCycle), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " commitReady"}, 32'(commitReady), 32'd1);
        check({tag, " frameCount"}, 32'(frameCount), 32'd0);
        check({tag, " overrunCount"}, 32'(overrunCount), 32'd0);
        check({tag, " timeoutFlag"}, 32'(timeoutFlag), 32'd0);
        check({tag, " dftBins nonzero"}, 32'(dftBins != '0), 32'd0);
    endtask

    // Expects to be called right after startCycle was seen; finished is given on the 50th WAIT edge.
    task automatic runFrame(output int period);
        int n;
        repeat (50) tick();
        nfFinished = 1'b1;
        tick();
        nfFinished = 1'b0;
        n = 51;
        while (!startCycle && n < 200) begin
            tick();
            n++;
        end
        period = n;
    endtask

    initial begin
        int bad;
        int per;
        int n;

        vecs[0] = '{2'd0, 1'b1, 7'd5, 16'hAAAA, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 16'd15};
        vecs[1] = '{2'd0, 1'b1, 7'd6, 16'hBBBB, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd15};
        vecs[2] = '{2'd0, 1'b1, 7'd5, 16'h1111, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 16'd15};
        vecs[3] = '{2'd0, 1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 16'd15};
        vecs[4] = '{2'd0, 1'b1, 7'd7, 16'h2222, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 16'd15};
        vecs[5] = '{2'd0, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 16'd15};
        vecs[6] = '{2'd3, 1'b0, 7'd0, 16'h0000, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 16'd15};
        vecs[7] = '{2'd3, 1'b1, 7'd5, 16'h3333, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 16'd15};

        rst         = 1'b0;
        mode        = 2'd0;
        binWrEn     = 1'b0;
        binWrIdx    = '0;
        binWrData   = '0;
        frameCommit = 1'b0;
        nfFinished  = 1'b0;
        #3;
        checkResetState("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Frame 1: out-of-range writes, then bins 0..119 = i*3, commit with the last write.
        mode = 2'd1;
        for (int i = 120; i < 128; i++) begin
            binWrEn = 1'b1; binWrIdx = 7'(i); binWrData = 16'hFFFF;
            tick();
        end
        for (int i = 0; i < BINS; i++) begin
            binWrEn = 1'b1; binWrIdx = 7'(i); binWrData = 16'(i * 3);
            frameCommit = (i == BINS - 1);
            tick();
        end
        binWrEn = 1'b0; frameCommit = 1'b0;
        check("A commitReady after commit", 32'(commitReady), 32'd0);
        check("A start not yet", 32'(startCycle), 32'd0);
        check("A bin119 before swap", 32'(dftBins[119]), 32'd0);
        tick();
        check("A startCycle", 32'(startCycle), 32'd1);
        check("A busy", 32'(busy), 32'd1);
        check("A bin119", 32'(dftBins[119]), 32'd357);
        bad = 0;
        for (int i = 0; i < BINS; i++) if (dftBins[i] !== 16'(i * 3)) bad++;
        check("A bank mismatches", 32'(bad), 32'd0);
        tick();
        check("A start one cycle", 32'(startCycle), 32'd0);
        repeat (698) tick();
        check("A frameCount before finish", 32'(frameCount), 32'd0);
        check("A busy in wait", 32'(busy), 32'd1);
        nfFinished = 1'b1;
        tick();
        nfFinished = 1'b0;
        check("A frameCount", 32'(frameCount), 32'd1);
        repeat (MIN_INTERVAL - 1) tick();
        check("A busy in holdoff", 32'(busy), 32'd1);
        tick();
        check("A busy idle", 32'(busy), 32'd0);
        check("A timeoutFlag", 32'(timeoutFlag), 32'd0);
        nfFinished = 1'b1;
        repeat (3) tick();
        nfFinished = 1'b0;
        check("finished ignored in idle", 32'(frameCount), 32'd1);

        // Table: commits and writes with no launch (OFF and reserved mode).
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode; binWrEn = vecs[i].wrEn; binWrIdx = vecs[i].idx;
            binWrData = vecs[i].data; frameCommit = vecs[i].commit;
            tick();
            check($sformatf("vec%0d commitReady", i), 32'(commitReady), 32'(vecs[i].expReady));
            check($sformatf("vec%0d overrun", i), 32'(overrunCount), 32'(vecs[i].expOvr));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
            check($sformatf("vec%0d start", i), 32'(startCycle), 32'(vecs[i].expStart));
            check($sformatf("vec%0d bin5", i), 32'(dftBins[5]), 32'(vecs[i].expBin5));
        end
        binWrEn = 1'b0; frameCommit = 1'b0;

        // Launch the pending frame and let it time out; commit a new frame during WAIT.
        mode = 2'd1;
        tick();
        check("C startCycle", 32'(startCycle), 32'd1);
        check("C commitReady", 32'(commitReady), 32'd1);
        check("C bin5", 32'(dftBins[5]), 32'hAAAA);
        check("C bin6", 32'(dftBins[6]), 32'hBBBB);
        check("C bin7 frozen", 32'(dftBins[7]), 32'd0);
        check("C bin119", 32'(dftBins[119]), 32'd0);
        tick();
        binWrEn = 1'b1; binWrIdx = 7'd0; binWrData = 16'h0ABC;
        tick();
        binWrIdx = 7'd2; binWrData = 16'h0DEF; frameCommit = 1'b1;
        tick();
        binWrEn = 1'b0; frameCommit = 1'b0;
        mode = 2'd2;
        check("C commit in wait", 32'(commitReady), 32'd0);
        repeat (TIMEOUT - 2) tick();
        check("C no timeout yet", 32'(timeoutFlag), 32'd0);
        check("C bins stable in wait", 32'(dftBins[0]), 32'd0);
        check("C busy in wait", 32'(busy), 32'd1);
        tick();
        check("C timeoutFlag", 32'(timeoutFlag), 32'd1);
        check("C frameCount unchanged", 32'(frameCount), 32'd1);
        repeat (MIN_INTERVAL - 1) tick();
        check("C busy in holdoff", 32'(busy), 32'd1);
        check("C bin2 stable", 32'(dftBins[2]), 32'hAAAA & 16'h0);
        tick();
        check("C idle", 32'(busy), 32'd0);
        check("C start not in idle", 32'(startCycle), 32'd0);
        tick();
        check("C swap start", 32'(startCycle), 32'd1);
        check("C swap bin0", 32'(dftBins[0]), 32'h0ABC);
        check("C swap bin2", 32'(dftBins[2]), 32'h0DEF);
        check("C swap bin1", 32'(dftBins[1]), 32'd3);
        check("C swap bin119", 32'(dftBins[119]), 32'd357);

        // REPEAT: relaunch the same bank every 1 + 50 + MIN_INTERVAL + 1 cycles.
        runFrame(per);
        check("D period 1", 32'(per), 32'd62);
        check("D frameCount 2", 32'(frameCount), 32'd2);
        check("D bin2 unchanged", 32'(dftBins[2]), 32'h0DEF);
        runFrame(per);
        check("D period 2", 32'(per), 32'd62);
        check("D frameCount 3", 32'(frameCount), 32'd3);
        check("D bin0 unchanged", 32'(dftBins[0]), 32'h0ABC);
        mode = 2'd0;
        runFrame(per);
        check("D off no relaunch", 32'(per), 32'd200);
        check("D frameCount 4", 32'(frameCount), 32'd4);
        check("D busy off", 32'(busy), 32'd0);

        // Reset in the middle of WAIT.
        mode = 2'd2;
        tick();
        check("E repeat start", 32'(startCycle), 32'd1);
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        checkResetState("E async reset");
        tick();
        rst = 1'b1;
        n = 0;
        while (!startCycle && n < 40) begin
            tick();
            n++;
        end
        check("E no start after reset", 32'(n), 32'd40);
        frameCommit = 1'b1;
        tick();
        frameCommit = 1'b0;
        check("E commit pending", 32'(commitReady), 32'd0);
        tick();
        check("E start after commit", 32'(startCycle), 32'd1);
        check("E bank cleared", 32'(dftBins != '0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nf_frame_sequencer.md
# nf_frame_sequencer

Synthesizable frame driver between the DFT bin producer and `NoteFinder`. Collects one frame of BINS unsigned bin magnitudes into a double-buffered bank, then launches the note finder with a one-cycle `startCycle` pulse. It waits for `finished` (or a timeout) instead of a fixed cycle budget, and supports off, on-commit and repeat-last-frame modes.

## Interface
Parameters:
- N, 16, bin magnitude width
- BPO, 24, bins per octave
- OCT, 5, octaves; BINS = BPO*OCT (localparam), IW = $clog2(BINS)
- TIMEOUT, 1023, max cycles to wait for `nfFinished`
- MIN_INTERVAL, 0, idle cycles enforced between `nfFinished` and the next launch

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  2  SeqMode: 0 OFF, 1 ON_COMMIT, 2 REPEAT, 3 treated as OFF
- binWrEn  in  1  write strobe into the write bank
- binWrIdx  in  IW  bin index; values >= BINS are ignored
- binWrData  in  N  bin value
- frameCommit  in  1  marks the write bank as a complete frame
- commitReady  out  1  high when no committed frame is pending
- dftBins  out  BINS x N  read bank, wired to `NoteFinder.dftBins`
- startCycle  out  1  one-cycle launch pulse to `NoteFinder`
- nfFinished  in  1  `NoteFinder.finished`
- busy  out  1  high in START, WAIT and HOLDOFF
- frameCount  out  16  frames completed via `nfFinished`; wraps
- overrunCount  out  8  rejected commits; saturates at 255
- timeoutFlag  out  1  sticky; set on timeout

## Operation
- There are two banks, selected by `rdSel`: the write bank is `~rdSel` and `dftBins` shows bank `rdSel`.
- `pending` is set by an accepted commit. `commitReady = ~pending`.
- Write bank:
  - A write with `pending=0` stores `binWrData` at `binWrIdx`.
  - A write with `pending=1` is dropped; the pending bank is frozen.
  - A write and a commit in the same cycle: the write lands first and is part of the committed frame.
- Commit:
  - `frameCommit` with `pending=0` sets `pending`.
  - `frameCommit` with `pending=1` increments `overrunCount` (saturating) and changes nothing else.
- FSM states: IDLE, START, WAIT, HOLDOFF.
- IDLE:
  - If mode is ON_COMMIT or REPEAT and `pending=1`: toggle `rdSel`, clear `pending`, set `everSwapped`, go to START.
  - Else if mode is REPEAT and `everSwapped=1`: go to START with no swap.
  - Else stay in IDLE.
- START: `startCycle=1` for exactly this one cycle; clear the wait counter; go to WAIT.
- WAIT:
  - On `nfFinished`: `frameCount++`, go to HOLDOFF.
  - Else if the wait counter reaches TIMEOUT: set `timeoutFlag`, go to HOLDOFF without a count.
  - Else increment the wait counter.
- HOLDOFF: wait MIN_INTERVAL cycles, then go to IDLE. With MIN_INTERVAL=0, skip HOLDOFF and go directly to IDLE.
- `nfFinished` is ignored outside WAIT.
- `dftBins` never changes while `busy=1`.
- A mode change while busy does not abort the current frame; it takes effect in IDLE.
- A commit accepted while busy is swapped in at the next IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - Both banks all-zero, `rdSel=0`, `pending=0`, `everSwapped=0`.
  - `startCycle=0`, `busy=0`, `commitReady=1`.
  - `frameCount=0`, `overrunCount=0`, `timeoutFlag=0`.
  - State IDLE.
- Commit latency, with `frameCommit` sampled at edge t and the FSM in IDLE:
  - `pending=1` after t.
  - The swap, new `dftBins` and `startCycle=1` all appear after edge t+1.
  - `startCycle` drops after t+2.
- Frame period = 1 (START) + cycles to `nfFinished` + MIN_INTERVAL + 1 (IDLE).
- Reset asserted mid-frame clears everything immediately (asynchronously); `startCycle` is never left high.

## Structure
- The CCHW package gets:
  - enum `SeqMode` {OFF, ON_COMMIT, REPEAT}
  - enum `SeqState` {IDLE, START, WAIT, HOLDOFF}
- Sub-module `nf_bin_bank #(N, BINS)`: two register banks with a write port, a bank select, and the full read-bank output.
- The FSM and counters stay in the top module.

## Test plan
- Write bins 0..119 with value i*3 in ON_COMMIT mode, commit -> `startCycle` high exactly 2 cycles after the commit edge; `dftBins[119]=357`; drive `nfFinished` 700 cycles later -> `frameCount=1`, `busy=0`.
- Commit twice with no launch (mode OFF) -> `overrunCount=1`, `commitReady=0`; the second frame's writes do not alter the pending bank.
- REPEAT mode after one commit, with `nfFinished` at 50 cycles and MIN_INTERVAL=10 -> `startCycle` pulses every 62 cycles on unchanged `dftBins`.
- `nfFinished` held low with TIMEOUT=100 -> `timeoutFlag=1` after 101 WAIT cycles, `frameCount` unchanged, FSM returns to IDLE.
- Commit during WAIT -> `dftBins` stable until `nfFinished`; swap and `startCycle` in the cycle after IDLE is re-entered.
- Reset asserted mid-WAIT -> all outputs take their reset values immediately, banks read 0, no `startCycle` after release until the next commit.
